// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer: packs 24-bit RGB pixels densely into 32-bit little-endian words; define RGB_STREAM_PACKER_FRAME_CHECK_EN to enable the frame-length checker
module rgb_stream_packer #(
  parameter int Height = 1080,
  parameter int Width = 1920
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        slave_valid_i,
  output logic        slave_ready_o,
  input  logic [7:0]  slave_red_i,
  input  logic [7:0]  slave_green_i,
  input  logic [7:0]  slave_blue_i,
  input  logic        slave_last_i,
  output logic        master_valid_o,
  input  logic        master_ready_i,
  output logic [31:0] master_data_o,
  output logic        master_last_o,
  output logic        frame_done_o,
  output logic        length_error_o
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [23:0] res_data;
  logic [1:0] res_cnt;
  logic [47:0] merged;
  logic [2:0] total;
  logic take, word_hs;
  assign word_hs = master_valid_o && master_ready_i;
  assign slave_ready_o = (state == RUN) && (!master_valid_o || master_ready_i);
  assign take = slave_valid_i && slave_ready_o;
  assign frame_done_o = word_hs && master_last_o;
  // residual bytes occupy the low lanes; the new pixel lands right after them
  always_comb begin
    merged = {24'b0, res_data} | ({24'b0, slave_blue_i, slave_green_i, slave_red_i} << {res_cnt, 3'b000});
    total = {1'b0, res_cnt} + 3'd3;
  end
  // output word register, residual bytes and RUN/FLUSH state
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= RUN;
      res_data <= '0;
      res_cnt <= '0;
      master_valid_o <= 1'b0;
      master_data_o <= '0;
      master_last_o <= 1'b0;
    end else if (state == FLUSH) begin
      if (!master_valid_o || master_ready_i) begin
        master_valid_o <= 1'b1;
        master_data_o <= {8'b0, res_data};
        master_last_o <= 1'b1;
        res_data <= '0;
        res_cnt <= '0;
        state <= RUN;
      end
    end else if (take) begin
      if (slave_last_i || total >= 3'd4) begin
        master_valid_o <= 1'b1;
        master_data_o <= merged[31:0];
        master_last_o <= slave_last_i && total <= 3'd4;
        res_data <= {8'b0, merged[47:32]};
        res_cnt <= total > 3'd4 ? 2'(total - 3'd4) : 2'd0;
        state <= (slave_last_i && total > 3'd4) ? FLUSH : RUN;
      end else begin
        res_data <= merged[23:0];
        res_cnt <= 2'(total);
        if (word_hs) master_valid_o <= 1'b0;
      end
    end else if (word_hs) begin
      master_valid_o <= 1'b0;
    end
  end
`ifdef RGB_STREAM_PACKER_FRAME_CHECK_EN
  localparam int Frame = Height * Width;
  localparam int Cw = $clog2(Frame + 1);
  logic [Cw-1:0] pix_cnt;
  // per-frame pixel count; a last pixel at the wrong count or a missing last sets the sticky error
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pix_cnt <= '0;
      length_error_o <= 1'b0;
    end else if (take) begin
      pix_cnt <= slave_last_i ? '0 : pix_cnt + 1'b1;
      if (slave_last_i ? pix_cnt != Cw'(Frame - 1) : pix_cnt == Cw'(Frame - 1)) length_error_o <= 1'b1;
    end
  end
`else
  assign length_error_o = (Height < 0) && (Width < 0);
`endif
endmodule
